// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: downstream-side hazard controller for the ID->EXE pipeline register.
// Detects RAW hazards against the EXE stage and a shadow copy of the MEM stage, drives
// freeze / id_flush / if_flush back to the front end, tracks a RUN/STALL/FLUSH state,
// keeps saturating stall/flush counters and a sticky stuck-stall watchdog.
// Build option: define FORWARDING_EN for a forwarding datapath (load-use hazards only);
// leave it undefined for a non-forwarding datapath (EXE and MEM dependencies both stall).
module hazard_scoreboard #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src2,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_b_taken,
  output logic             freeze,
  output logic             id_flush,
  output logic             if_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // The run-length counter only has to reach MAX_STALL; one more hazard cycle trips the watchdog.
  localparam int               RUN_W     = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             mem_r_en;
  logic             match_exe;
  logic             match_mem;
  logic             raw;
  logic             unused_shadow;
  logic [RUN_W-1:0] run_len;
  state_e           cur_st;
  state_e           nxt_st;

  // Source/destination compare against each checked stage; R15 is treated like any register.
  assign match_exe = exe_wb_en & ((id_src1 == exe_dest) | (id_use_src2 & (id_src2 == exe_dest)));
  assign match_mem = mem_wb_en & ((id_src1 == mem_dest) | (id_use_src2 & (id_src2 == mem_dest)));

  // WB is never checked: the register file writes in the first half-cycle.
`ifdef FORWARDING_EN
  // Forwarding covers everything except a load whose data is not ready until MEM.
  assign raw           = id_valid & exe_mem_r_en & match_exe;
  assign unused_shadow = match_mem ^ mem_r_en;
`else
  assign raw           = id_valid & (match_exe | match_mem);
  assign unused_shadow = mem_r_en;
`endif

  // Front-end controls and next FSM state; a taken branch overrides any hazard.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    freeze   = 1'b0;
    id_flush = 1'b0;
    if_flush = 1'b0;
    nxt_st   = ST_RUN;
    if (exe_b_taken) begin
      nxt_st = ST_FLUSH;
    end else if (raw) begin
      nxt_st = ST_STALL;
    end
    if (!rst) begin
      if (exe_b_taken) begin
        if_flush = 1'b1;
        id_flush = 1'b1;
      end else begin
        freeze   = raw;
        id_flush = raw;
      end
    end
  end

  // MEM shadow follows the ID->EXE register every cycle, freeze or not; bubbles arrive as wb_en=0.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_dest  <= 4'd0;
      mem_wb_en <= 1'b0;
      mem_r_en  <= 1'b0;
    end else begin
      mem_dest  <= exe_dest;
      mem_wb_en <= exe_wb_en;
      mem_r_en  <= exe_mem_r_en;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) cur_st <= ST_RUN;
    else     cur_st <= nxt_st;
  end

  assign state = cur_st;

  // Consecutive-hazard run length and the sticky watchdog it feeds.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_len   <= '0;
      stall_err <= 1'b0;
    end else if (raw && !exe_b_taken) begin
      if (run_len == RUN_LIMIT) stall_err <= 1'b1;
      else                      run_len   <= run_len + RUN_W'(1);
    end else begin
      run_len <= '0;
    end
  end

  // Saturating totals of stall cycles and taken-branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze && (stall_cnt != CNT_MAX))      stall_cnt <= stall_cnt + CNT_W'(1);
      if (exe_b_taken && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized stimulus against a behavioural model.
// The driver pushes the expected response for each applied vector into a queue; a monitor
// on the falling edge pops and compares. Two instances share inputs: one with wide counters,
// one with 2-bit counters so saturation is exercised.
module tb_hazard_scoreboard;

  localparam int MAX_STALL = 4;
  localparam int W_A       = 16;
  localparam int W_S       = 2;

  typedef struct {
    bit       rst;
    bit       valid;
    bit [3:0] src1;
    bit [3:0] src2;
    bit       use2;
    bit       wb;
    bit       rd;
    bit [3:0] dest;
    bit       b;
  } in_t;

  typedef struct {
    bit freeze;
    bit id_flush;
    bit if_flush;
    int st;
    int stall;
    int flush;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rst, id_valid, id_use_src2, exe_wb_en, exe_mem_r_en, exe_b_taken;
  logic [3:0] id_src1, id_src2, exe_dest;

  logic           freeze_a, id_flush_a, if_flush_a, err_a;
  logic [1:0]     state_a;
  logic [W_A-1:0] stall_a, flush_a;
  logic           freeze_s, id_flush_s, if_flush_s, err_s;
  logic [1:0]     state_s;
  logic [W_S-1:0] stall_s, flush_s;

  hazard_scoreboard #(.CNT_W(W_A), .MAX_STALL(MAX_STALL)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_dest(exe_dest), .exe_b_taken(exe_b_taken), .freeze(freeze_a), .id_flush(id_flush_a),
    .if_flush(if_flush_a), .state(state_a), .stall_cnt(stall_a), .flush_cnt(flush_a),
    .stall_err(err_a)
  );

  hazard_scoreboard #(.CNT_W(W_S), .MAX_STALL(MAX_STALL)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_dest(exe_dest), .exe_b_taken(exe_b_taken), .freeze(freeze_s), .id_flush(id_flush_s),
    .if_flush(if_flush_s), .state(state_s), .stall_cnt(stall_s), .flush_cnt(flush_s),
    .stall_err(err_s)
  );

  always #5 clk = ~clk;

  // Reference model: what the MEM stage holds, plus plain integer totals.
  bit [3:0] m_dest;
  bit       m_wb;
  int       m_run, m_stall, m_flush, m_st;
  bit       m_err;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  in_t  cur;

  function automatic bit reads(in_t v, bit wb, bit [3:0] d);
    return wb && (v.src1 == d || (v.use2 && v.src2 == d));
  endfunction

  function automatic bit hazard(in_t v);
`ifdef FORWARDING_EN
    return v.valid && v.rd && reads(v, v.wb, v.dest);
`else
    return v.valid && (reads(v, v.wb, v.dest) || reads(v, m_wb, m_dest));
`endif
  endfunction

  function automatic int sat(int x, int w);
    int lim = (1 << w) - 1;
    return (x > lim) ? lim : x;
  endfunction

  // Advance the model across one clock edge with the inputs that were applied before it.
  task automatic model_edge(in_t v);
    bit h;
    if (v.rst) begin
      m_dest = 0; m_wb = 0; m_run = 0; m_stall = 0; m_flush = 0; m_st = 0; m_err = 0;
    end else begin
      h = hazard(v);
      if (v.b)      m_flush++;
      else if (h)   m_stall++;
      m_st = v.b ? 2 : (h ? 1 : 0);
      if (h && !v.b) begin
        m_run++;
        if (m_run > MAX_STALL) m_err = 1;
      end else begin
        m_run = 0;
      end
      m_dest = v.dest;
      m_wb   = v.wb;
    end
  endtask

  task automatic drive(in_t v);
    rst = v.rst; id_valid = v.valid; id_src1 = v.src1; id_src2 = v.src2; id_use_src2 = v.use2;
    exe_wb_en = v.wb; exe_mem_r_en = v.rd; exe_dest = v.dest; exe_b_taken = v.b;
  endtask

  // One cycle: settle the model over the edge, apply the next vector, queue its expectation.
  task automatic apply(in_t v);
    exp_t e;
    bit   h;
    @(posedge clk);
    #1;
    model_edge(cur);
    cur = v;
    drive(v);
    h = hazard(v);
    e.freeze   = !v.rst && !v.b && h;
    e.id_flush = !v.rst && (v.b || h);
    e.if_flush = !v.rst && v.b;
    e.st       = m_st;
    e.stall    = m_stall;
    e.flush    = m_flush;
    e.err      = m_err;
    exp_q.push_back(e);
  endtask

  function automatic in_t mk(bit valid, bit [3:0] s1, bit [3:0] s2, bit u2, bit wb, bit rd,
                             bit [3:0] d, bit b);
    in_t v;
    v.rst = 0; v.valid = valid; v.src1 = s1; v.src2 = s2; v.use2 = u2;
    v.wb = wb; v.rd = rd; v.dest = d; v.b = b;
    return v;
  endfunction

  // Registers drawn from a small pool (plus R15) so dependencies occur often.
  function automatic bit [3:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  function automatic in_t rnd();
    in_t v;
    v = mk($urandom_range(0, 5) != 0, rreg(), rreg(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rreg(),
           $urandom_range(0, 7) == 0);
    v.rst = ($urandom_range(0, 199) == 0);
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a fresh response every cycle; compare away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      check("freeze",      int'(freeze_a),   int'(e.freeze));
      check("id_flush",    int'(id_flush_a), int'(e.id_flush));
      check("if_flush",    int'(if_flush_a), int'(e.if_flush));
      check("state",       int'(state_a),    e.st);
      check("stall_cnt",   int'(stall_a),    sat(e.stall, W_A));
      check("flush_cnt",   int'(flush_a),    sat(e.flush, W_A));
      check("stall_err",   int'(err_a),      int'(e.err));
      check("freeze_n2",   int'(freeze_s),   int'(e.freeze));
      check("state_n2",    int'(state_s),    e.st);
      check("stall_cnt_n2", int'(stall_s),   sat(e.stall, W_S));
      check("flush_cnt_n2", int'(flush_s),   sat(e.flush, W_S));
      check("stall_err_n2", int'(err_s),     int'(e.err));
    end
  end

  initial begin
    in_t ones;
    ones = mk(1, 4'hf, 4'hf, 1, 1, 1, 4'hf, 1);
    ones.rst = 1;
    cur = ones;
    drive(ones);
    m_dest = 0; m_wb = 0; m_run = 0; m_stall = 0; m_flush = 0; m_st = 0; m_err = 0;

    // Reset held two cycles with every input high.
    apply(ones);
    apply(ones);
    // Dependency on EXE, then on the MEM shadow after the producer moves on.
    apply(mk(1, 4'd3, 4'd0, 0, 1, 0, 4'd3, 0));
    apply(mk(1, 4'd3, 4'd0, 0, 0, 0, 4'd7, 0));
    apply(mk(1, 4'd3, 4'd0, 0, 0, 0, 4'd7, 0));
    // Load-use through src2, with and without src2 in use.
    apply(mk(1, 4'd1, 4'd5, 1, 1, 1, 4'd5, 0));
    apply(mk(1, 4'd1, 4'd5, 0, 0, 0, 4'd9, 0));
    apply(mk(1, 4'd1, 4'd5, 0, 1, 1, 4'd5, 0));
    apply(mk(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0));
    apply(mk(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0));
    // Hazard and taken branch together, then a second branch back to back.
    apply(mk(1, 4'd5, 4'd0, 0, 1, 1, 4'd5, 1));
    apply(mk(1, 4'd5, 4'd0, 0, 1, 1, 4'd5, 1));
    apply(mk(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0));
    apply(mk(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0));
    // Hazard held six cycles trips the watchdog; it stays set once the hazard clears.
    for (int i = 0; i < 6; i++) apply(mk(1, 4'd15, 4'd0, 0, 1, 1, 4'd15, 0));
    for (int i = 0; i < 4; i++) apply(mk(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0));
    // Five taken branches: the 2-bit counters stop at 3.
    for (int i = 0; i < 5; i++) apply(mk(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 1));
    // Reset in the middle of a stall.
    apply(mk(1, 4'd2, 4'd0, 0, 1, 1, 4'd2, 0));
    begin
      in_t r;
      r = mk(1, 4'd2, 4'd0, 0, 1, 1, 4'd2, 0);
      r.rst = 1;
      apply(r);
    end
    apply(mk(1, 4'd2, 4'd0, 0, 0, 0, 4'd8, 0));
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) apply(rnd());

    @(posedge clk);
    #2;
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d responses unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
